// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the iterative DIV/DIVU sequencer: state encodings,
// default widths and the SPECIAL-opcode funct codes that select the divider.
package div_seq_ctrl_pkg;

    localparam int DIV_W_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_DZERO = 2'd1,
        DIV_BUSY  = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_datapath.sv
// Restoring-division datapath: operand latch with absolute value, one
// shift/compare/subtract step per cycle, and sign fix-up of the result.
module div_seq_ctrl_datapath
    import div_seq_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load_i,
    input  logic               signed_i,
    input  logic [DIV_W-1:0]   opdata1_i,
    input  logic [DIV_W-1:0]   opdata2_i,
    input  logic               dzero_i,
    input  logic               step_i,
    input  logic               commit_i,
    output logic [2*DIV_W-1:0] result_o
);

    logic [DIV_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [DIV_W-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*DIV_W-1:0] result_q, result_d;

    logic               sign1, sign2;
    logic [DIV_W-1:0]   dvd_abs, dvs_abs;
    logic [DIV_W:0]     rem_sh, diff;
    logic [DIV_W-1:0]   rem_fix, quo_fix;

    always_comb begin
        sign1   = signed_i & opdata1_i[DIV_W-1];
        sign2   = signed_i & opdata2_i[DIV_W-1];
        dvd_abs = sign1 ? -opdata1_i : opdata1_i;
        dvs_abs = sign2 ? -opdata2_i : opdata2_i;
        // Borrow out of the (DIV_W+1)-bit subtract means rem < divisor.
        rem_sh  = {rem_q, quo_q[DIV_W-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        rem_fix = rneg_q ? -rem_q : rem_q;
        quo_fix = qneg_q ? -quo_q : quo_q;
    end

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        if (load_i) begin
            rem_d  = '0;
            quo_d  = dvd_abs;
            dvs_d  = dvs_abs;
            qneg_d = sign1 ^ sign2;
            rneg_d = sign1;
        end else if (dzero_i) begin
            rem_d = quo_q;
            quo_d = '1;
        end else if (step_i) begin
            if (!diff[DIV_W]) begin
                rem_d = diff[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b0};
            end
        end
        if (commit_i) begin
            result_d = {rem_fix, quo_fix};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // The fixed-up result is visible in the DONE cycle itself, then held.
    assign result_o = commit_i ? {rem_fix, quo_fix} : result_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencing FSM: stall, step counter and ready pulse.
// Define DIV_ZERO_FAST_EN to short-cut a zero divisor through DIV_DZERO.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [DIV_W-1:0]   opdata1_i,
    input  logic [DIV_W-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*DIV_W-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, step, dzero;
    logic             zero_dvs;

`ifdef DIV_ZERO_FAST_EN
    assign zero_dvs = (opdata2_i == '0);
`else
    assign zero_dvs = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        dzero   = 1'b0;
        ready_o = 1'b0;
        if (annul_i) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = zero_dvs ? DIV_DZERO : DIV_BUSY;
                    end
                end
                DIV_DZERO: begin
                    dzero   = 1'b1;
                    state_d = DIV_DONE;
                end
                DIV_BUSY: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_W - 1)) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    ready_o = 1'b1;
                    state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    assign stall_o = start_i & (state_q != DIV_DONE) & ~annul_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    div_seq_ctrl_datapath #(
        .DIV_W(DIV_W)
    ) u_dp (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (load),
        .signed_i (signed_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .dzero_i  (dzero),
        .step_i   (step),
        .commit_i (ready_o),
        .result_o (result_o)
    );

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, signed/unsigned results,
// divide-by-zero, annul, back-to-back and mid-division reset.
module tb_div_seq_ctrl;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start_i;
    logic          signed_i;
    logic [W-1:0]  opdata1_i;
    logic [W-1:0]  opdata2_i;
    logic          annul_i;
    logic [2*W-1:0] result_o;
    logic          ready_o;
    logic          stall_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .annul_i  (annul_i),
        .result_o (result_o),
        .ready_o  (ready_o),
        .stall_o  (stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    // Holds start until ready; scrambles operands after acceptance.
    task automatic do_div(input string tag, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int  c;
        bit  stall_ok;
        bit  got;
        c        = 0;
        stall_ok = 1'b1;
        got      = 1'b0;
        while (!got && c < 100) begin
            @(negedge clk);
            start_i   = 1'b1;
            signed_i  = (c == 0) ? sg : ~sg;
            opdata1_i = (c == 0) ? a : $urandom;
            opdata2_i = (c == 0) ? b : $urandom;
            #1;
            if (ready_o) begin
                got = 1'b1;
                chk({tag, "_lat"}, 64'(c), 64'(exp_lat));
                chk({tag, "_res"}, result_o, exp_res);
                chk({tag, "_stall_done"}, 64'(stall_o), 64'd0);
            end else begin
                if (stall_o !== 1'b1) stall_ok = 1'b0;
                c++;
            end
        end
        chk({tag, "_ready_seen"}, 64'(got), 64'd1);
        chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    endtask

    task automatic idle_cycle(input logic [63:0] exp_res);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("idle_ready", 64'(ready_o), 64'd0);
        chk("idle_hold", result_o, exp_res);
    endtask

    initial begin
        resetn    = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        idle_cycle({32'd2, 32'd14});

        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
               {32'd1, 32'hFFFF_FFFD}, 33);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, 33);
        idle_cycle({32'd0, 32'h8000_0000});

        do_div("div_5_0", 1'b1, 32'd5, 32'd0,
               {32'd5, 32'hFFFF_FFFF}, ZLAT);
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0,
               {32'hFFFF_FFFB, 32'd1}, ZLAT);
        do_div("divu_max_0", 1'b0, 32'hFFFF_FFFF, 32'd0,
               {32'hFFFF_FFFF, 32'hFFFF_FFFF}, ZLAT);
        idle_cycle({32'hFFFF_FFFF, 32'hFFFF_FFFF});

        // Annul in cycle 10 of a DIVU 9/3, then restart immediately.
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            start_i   = 1'b1;
            signed_i  = 1'b0;
            opdata1_i = 32'd9;
            opdata2_i = 32'd3;
            annul_i   = (c == 10);
            #1;
            if (c == 10) begin
                chk("annul_ready", 64'(ready_o), 64'd0);
                chk("annul_stall", 64'(stall_o), 64'd0);
                chk("annul_hold", result_o,
                    {32'hFFFF_FFFF, 32'hFFFF_FFFF});
            end
        end
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        chk("post_annul_ready", 64'(ready_o), 64'd0);
        chk("post_annul_stall", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        do_div("divu_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
        do_div("divu_17_4", 1'b0, 32'd17, 32'd4, {32'd1, 32'd4}, 33);
        idle_cycle({32'd1, 32'd4});

        // Reset in cycle 15 of a busy division.
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            start_i   = 1'b1;
            signed_i  = 1'b0;
            opdata1_i = 32'd1000;
            opdata2_i = 32'd3;
            resetn    = (c != 15);
        end
        @(negedge clk);
        resetn  = 1'b1;
        start_i = 1'b0;
        #1;
        chk("mid_rst_result", result_o, 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd0);
        chk("mid_rst_stall0", 64'(stall_o), 64'd0);
        start_i = 1'b1;
        #1;
        chk("mid_rst_stall1", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        do_div("after_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);
        idle_cycle({32'd1, 32'd333});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
